// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz VGA timing constants and the raster coordinate type.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int DEF_CLK_DIV = 4;

  localparam int DEF_H_DISP = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;

  localparam int DEF_V_DISP = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int DEF_H_TOTAL      = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL      = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_SYNC_START = DEF_H_DISP + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int DEF_V_SYNC_START = DEF_V_DISP + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_tick_gen.sv
// Board-clock divider producing a registered one-clk pixel-rate enable.
module vga_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  // A one-bit divider for CLK_DIV=1 sticks at 0, which keeps p_tick high after reset.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;

  always_comb begin
    div_d  = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
    tick_d = (div_d == DIV_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign p_tick = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA raster counter with registered sync/blanking qualifiers.
// Optional frame_tick output enabled by defining VGA_FRAME_TICK_EN.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int H_DISP  = DEF_H_DISP,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_DISP  = DEF_V_DISP,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync
`ifdef VGA_FRAME_TICK_EN
  , output logic             frame_tick
`endif
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam coord_t H_MAX    = coord_t'(H_TOTAL - 1);
  localparam coord_t V_MAX    = coord_t'(V_TOTAL - 1);
  localparam coord_t H_DISP_C = coord_t'(H_DISP);
  localparam coord_t V_DISP_C = coord_t'(V_DISP);
  localparam coord_t H_SS     = coord_t'(H_DISP + H_FP);
  localparam coord_t H_SE     = coord_t'(H_DISP + H_FP + H_SYNC - 1);
  localparam coord_t V_SS     = coord_t'(V_DISP + V_FP);
  localparam coord_t V_SE     = coord_t'(V_DISP + V_FP + V_SYNC - 1);

  logic   tick;
  coord_t h_q, h_d, v_q, v_d;
  logic   h_wrap, v_wrap;
  logic   hs_q, vs_q, von_q;

  vga_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (tick)
  );

  always_comb begin
    h_wrap = (h_q == H_MAX);
    v_wrap = (v_q == V_MAX);
    h_d    = h_wrap ? '0 : h_q + 1'b1;
    v_d    = v_q;
    if (h_wrap) v_d = v_wrap ? '0 : v_q + 1'b1;
  end

  // Qualifiers are derived from the next counts so they change on the same edge as the coordinates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      von_q <= 1'b0;
    end else if (tick) begin
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= ~in_window(h_d, H_SS, H_SE);
      vs_q  <= ~in_window(v_d, V_SS, V_SE);
      von_q <= (h_d < H_DISP_C) && (v_d < V_DISP_C);
    end
  end

`ifdef VGA_FRAME_TICK_EN
  logic frame_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_q <= 1'b0;
    else       frame_q <= tick && h_wrap && v_wrap;
  end

  assign frame_tick = frame_q;
`endif

  assign p_tick   = tick;
  assign pixel_x  = h_q;
  assign pixel_y  = v_q;
  assign video_on = von_q;
  assign hsync    = hs_q;
  assign vsync    = vs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance plus two shrunken-timing instances.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   = 1'b1;
  logic rst_s = 1'b1;

  typedef struct {
    int d, hd, hfp, hsy, hbp, vd, vfp, vsy, vbp;
  } tim_t;

  typedef struct packed {
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       ft;
  } obs_t;

  typedef struct {
    int   k;
    int   x;
    int   y;
    logic pt;
    logic von;
    logic hs;
    logic vs;
  } vec_t;

  tim_t TBIG = '{d:4, hd:640, hfp:16, hsy:96, hbp:48, vd:480, vfp:10, vsy:2, vbp:33};
  tim_t TS1  = '{d:1, hd:8, hfp:2, hsy:3, hbp:2, vd:6, vfp:1, vsy:2, vbp:1};
  tim_t TS3  = '{d:3, hd:8, hfp:2, hsy:3, hbp:2, vd:6, vfp:1, vsy:2, vbp:1};

  logic       b_pt, b_von, b_hs, b_vs, b_ft;
  logic [9:0] b_x, b_y;
  logic       s1_pt, s1_von, s1_hs, s1_vs, s1_ft;
  logic [9:0] s1_x, s1_y;
  logic       s3_pt, s3_von, s3_hs, s3_vs, s3_ft;
  logic [9:0] s3_x, s3_y;

  vga_sync_gen dut (
    .clk(clk), .reset(rst), .p_tick(b_pt), .pixel_x(b_x), .pixel_y(b_y),
    .video_on(b_von), .hsync(b_hs), .vsync(b_vs)
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(b_ft)
`endif
  );

  vga_sync_gen #(.CLK_DIV(1), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                 .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_s1 (
    .clk(clk), .reset(rst_s), .p_tick(s1_pt), .pixel_x(s1_x), .pixel_y(s1_y),
    .video_on(s1_von), .hsync(s1_hs), .vsync(s1_vs)
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(s1_ft)
`endif
  );

  vga_sync_gen #(.CLK_DIV(3), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                 .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_s3 (
    .clk(clk), .reset(rst_s), .p_tick(s3_pt), .pixel_x(s3_x), .pixel_y(s3_y),
    .video_on(s3_von), .hsync(s3_hs), .vsync(s3_vs)
`ifdef VGA_FRAME_TICK_EN
    , .frame_tick(s3_ft)
`endif
  );

`ifndef VGA_FRAME_TICK_EN
  assign b_ft  = 1'b0;
  assign s1_ft = 1'b0;
  assign s3_ft = 1'b0;
`endif

  obs_t ob_big, ob_s1, ob_s3;
  always_comb begin
    ob_big = {b_pt, b_x, b_y, b_von, b_hs, b_vs, b_ft};
    ob_s1  = {s1_pt, s1_x, s1_y, s1_von, s1_hs, s1_vs, s1_ft};
    ob_s3  = {s3_pt, s3_x, s3_y, s3_von, s3_hs, s3_vs, s3_ft};
  end

  int errors = 0;
  int checks = 0;

  // Clock edges seen since the last reset release (0 while reset is held).
  int kb = 0;
  int ks = 0;
  always @(posedge clk or posedge rst)   if (rst)   kb <= 0; else kb <= kb + 1;
  always @(posedge clk or posedge rst_s) if (rst_s) ks <= 0; else ks <= ks + 1;

  // Reference: after k edges the raster has advanced by the number of pixel enables that
  // preceded those edges; the position is that count modulo the frame size.
  function automatic obs_t model(tim_t t, int k);
    obs_t e;
    int ht, vt, n, pos, px, py;
    ht  = t.hd + t.hfp + t.hsy + t.hbp;
    vt  = t.vd + t.vfp + t.vsy + t.vbp;
    n   = (k >= 1) ? (k / t.d - ((t.d == 1) ? 1 : 0)) : 0;
    pos = n % (ht * vt);
    px  = pos % ht;
    py  = pos / ht;
    e.pt = (k >= 1) && ((k % t.d) == (t.d - 1));
    e.x  = 10'(px);
    e.y  = 10'(py);
    if (n == 0) begin
      e.von = 1'b0;
      e.hs  = 1'b1;
      e.vs  = 1'b1;
    end else begin
      e.von = (px < t.hd) && (py < t.vd);
      e.hs  = !((px >= t.hd + t.hfp) && (px < t.hd + t.hfp + t.hsy));
      e.vs  = !((py >= t.vd + t.vfp) && (py < t.vd + t.vfp + t.vsy));
    end
`ifdef VGA_FRAME_TICK_EN
    e.ft = (k >= 2) && ((k % t.d) == 0) && (pos == 0) && (n > 0);
`else
    e.ft = 1'b0;
`endif
    return e;
  endfunction

  task automatic check(string nm, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got pt=%b x=%0d y=%0d von=%b hs=%b vs=%b ft=%b, want pt=%b x=%0d y=%0d von=%b hs=%b vs=%b ft=%b",
               nm, $time, act.pt, act.x, act.y, act.von, act.hs, act.vs, act.ft,
               exp.pt, exp.x, exp.y, exp.von, exp.hs, exp.vs, exp.ft);
    end
  endtask

  always @(negedge clk) begin
    check("big_model", ob_big, model(TBIG, rst ? 0 : kb));
    check("s1_model",  ob_s1,  model(TS1, rst_s ? 0 : ks));
    check("s3_model",  ob_s3,  model(TS3, rst_s ? 0 : ks));
  end

  vec_t tbl[13];

  task automatic run_table(string tag);
    for (int i = 0; i < 13; i++) begin
      obs_t exp;
      int   guard = 0;
      while (kb < tbl[i].k && guard < 10000) begin
        @(negedge clk);
        guard++;
      end
      #1;
      exp = {tbl[i].pt, 10'(tbl[i].x), 10'(tbl[i].y), tbl[i].von, tbl[i].hs, tbl[i].vs, 1'b0};
      if (kb != tbl[i].k) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: edge count %0d, required %0d", tag, kb, tbl[i].k);
      end else begin
        check($sformatf("%s_k%0d", tag, tbl[i].k), ob_big, exp);
      end
    end
  endtask

  initial begin
    tbl[0]  = '{k:1,    x:0,   y:0, pt:0, von:0, hs:1, vs:1};
    tbl[1]  = '{k:3,    x:0,   y:0, pt:1, von:0, hs:1, vs:1};
    tbl[2]  = '{k:4,    x:1,   y:0, pt:0, von:1, hs:1, vs:1};
    tbl[3]  = '{k:2556, x:639, y:0, pt:0, von:1, hs:1, vs:1};
    tbl[4]  = '{k:2560, x:640, y:0, pt:0, von:0, hs:1, vs:1};
    tbl[5]  = '{k:2620, x:655, y:0, pt:0, von:0, hs:1, vs:1};
    tbl[6]  = '{k:2624, x:656, y:0, pt:0, von:0, hs:0, vs:1};
    tbl[7]  = '{k:3004, x:751, y:0, pt:0, von:0, hs:0, vs:1};
    tbl[8]  = '{k:3008, x:752, y:0, pt:0, von:0, hs:1, vs:1};
    tbl[9]  = '{k:3196, x:799, y:0, pt:0, von:0, hs:1, vs:1};
    tbl[10] = '{k:3200, x:0,   y:1, pt:0, von:1, hs:1, vs:1};
    tbl[11] = '{k:3203, x:0,   y:1, pt:1, von:1, hs:1, vs:1};
    tbl[12] = '{k:4400, x:300, y:1, pt:0, von:1, hs:1, vs:1};

    repeat (3) @(negedge clk);
    #2;
    rst   = 1'b0;
    rst_s = 1'b0;

    run_table("line");

    // Mid-line reset must clear everything before the next clock edge.
    #1 rst = 1'b1;
    #1 check("async_reset", ob_big, {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    run_table("restart");

    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(20, 600)) @(negedge clk);
      #2 rst_s = 1'b1;
      #1 check("s1_async_reset", ob_s1, {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0});
      repeat ($urandom_range(1, 3)) @(posedge clk);
      @(negedge clk);
      #2 rst_s = 1'b0;
    end
    repeat (1000) @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Free-running 640x480@60 Hz VGA timing generator. It produces the `pixel_x`/`pixel_y` coordinate bus consumed by every overlay/text display block (start screen, score, sprites) and drives `hsync`/`vsync` to the connector. It sits between the 100 MHz board clock and all pixel-generation logic. It is the single source of raster position in the design.

## Interface
- `CLK_DIV`, 4: board clocks per pixel; 100 MHz / 4 = 25 MHz pixel rate.
- `H_DISP`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal timing in pixels.
- `V_DISP`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical timing in lines.
- `clk` input 1: board clock, 100 MHz.
- `reset` input 1: asynchronous, active-high.
- `p_tick` output 1: one-`clk` pulse per pixel; pixel enable for downstream logic.
- `pixel_x` output 10: horizontal count, 0..H_total-1, where H_total = 800.
- `pixel_y` output 10: vertical count, 0..V_total-1, where V_total = 525.
- `video_on` output 1: high when `pixel_x < H_DISP` and `pixel_y < V_DISP`.
- `hsync` output 1: active-low horizontal sync.
- `vsync` output 1: active-low vertical sync.
- `frame_tick` output 1: only with `VGA_FRAME_TICK_EN`.
- Clock `clk`; reset `reset`, asynchronous, active-high.

## Operation
- Divider counter `div` runs 0..CLK_DIV-1 on every `clk` and wraps to 0. `p_tick` is high while `div == CLK_DIV-1`.
- On each `p_tick`, `h_count` advances. At H_total-1 it wraps to 0 and `v_count` advances. At V_total-1 `v_count` wraps to 0.
- `hsync` and `vsync` are registered from the next count values, so they are coherent with `pixel_x`/`pixel_y`:
  - `hsync` is 0 when h is in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1] = [656, 751].
  - `vsync` is 0 when v is in [490, 491].
- `video_on` is registered the same way. Consumers see the coordinate and all qualifiers change on the same `clk` edge.
- Widths:
  - Counters are 10 bits; H_total-1 = 799 and V_total-1 = 524 both fit.
  - The divider is sized by `$clog2(CLK_DIV)`.
  - CLK_DIV=1 is legal: `p_tick` is constantly 1.
- The block has no inputs besides clock and reset. It never stalls.

## Timing
- Reset values, asserted asynchronously: `div=0`, `pixel_x=0`, `pixel_y=0`, `hsync=1`, `vsync=1`, `video_on=0`, `p_tick=0`, `frame_tick=0`.
- First `p_tick`: CLK_DIV `clk` edges after reset deassertion. The first coordinate update after reset is (1,0).
- `video_on` becomes 1 after the first `p_tick` and covers (1,0) onward. Pixel (0,0) is visible from the second frame on. This is acceptable and intended.
- One line = 800 `p_tick` = 3200 `clk`. One frame = 420000 pixels = 1,680,000 `clk`.
- Simultaneous wrap at (799,524) goes to (0,0) in one `p_tick`. `vsync` and `hsync` update on that same edge.
- Reset mid-frame: all state clears immediately. Counting restarts from (0,0) with no partial line emitted after release.

## Configuration
- `VGA_FRAME_TICK_EN` defined:
  - Adds output `frame_tick` (1 bit).
  - Registered high for exactly one `clk`, coincident with the `p_tick` on which the counts move to (0,0).
  - Used by game logic for per-frame updates.
- `VGA_FRAME_TICK_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `vga_timing_pkg` holds:
  - the default timing constants;
  - the derived H_total, V_total, sync start and sync end values;
  - the 10-bit coordinate width constant.
- Sub-module `vga_tick_gen` (CLK_DIV divider, outputs `p_tick`) is natural. It is reused by other blocks that need the pixel rate.
- Counter and sync logic stay in `vga_sync_gen`.

## Test plan
- Reset held, then released:
  - During reset, outputs read (0,0), `hsync=1`, `vsync=1`, `video_on=0`.
  - First `p_tick` at `clk` 4 after release; counts become (1,0) with `video_on=1`.
- Run one line:
  - `hsync` falls when x=656 and rises when x=752; low width = 96 `p_tick` = 384 `clk`.
  - `video_on` falls when x=640.
- Run one frame:
  - `vsync` low exactly for y=490..491 (1600 `p_tick`).
  - `video_on=0` for all y ≥ 480.
- Line/frame wrap: at (799,524), the next `p_tick` gives (0,0). Period between consecutive (0,0) is 1,680,000 `clk`.
- Assert `reset` at (300,200) for 3 `clk`:
  - Outputs clear asynchronously.
  - After release, counts restart from (0,0) with the first `p_tick` 4 `clk` later.
- `VGA_FRAME_TICK_EN` defined: `frame_tick` pulses once per 1,680,000 `clk`, 1 `clk` wide, on the edge entering (0,0). It never pulses on the first coordinate update after reset.
